uart_rx_cmd_ctrl: RTL
=====================

Name: uart_rx_cmd_ctrl

Overview:
- Command sequencer downstream of UART_RX. Consumes received bytes (P_DATA/DATA_VALID) and receiver error flags.
- Parses multi-byte command frames and issues single-cycle register-file write/read and ALU-start strobes.
- Holds response-producing commands until the TX path is idle.
- Aborts on receiver errors, unknown opcodes and inter-byte timeout.

Parameters:
- DATA_WIDTH, 8, byte width; must match UART_RX.
- ADDR_WIDTH, 4, register-file address width; address is P_DATA[ADDR_WIDTH-1:0].
- TIMEOUT, 50000, max CLK cycles between bytes inside a frame; must be ≥2.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset; asynchronous, active-high.
- RX_P_DATA  in  DATA_WIDTH  received byte from UART_RX.
- RX_D_VLD  in  1  one-cycle byte-valid pulse.
- RX_ERR  in  1  Parity_Error OR Frame_Error from UART_RX.
- TX_BUSY  in  1  response path busy; read/ALU issue stalls while high.
- RF_WR_EN  out  1  one-cycle write strobe.
- RF_RD_EN  out  1  one-cycle read strobe.
- RF_ADDR  out  ADDR_WIDTH  register-file address.
- RF_WR_DATA  out  DATA_WIDTH  write data.
- ALU_EN  out  1  one-cycle ALU start strobe.
- ALU_FUN  out  4  ALU function = FUN byte [3:0].
- CMD_ERR  out  1  one-cycle abort/reject pulse.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered. On reset: all outputs 0, state IDLE, timer 0. Reset mid-frame discards the partial frame; no strobe is issued.
- Opcodes (first byte):
  - 0xAA write: ADDR, DATA.
  - 0xBB read: ADDR.
  - 0xCC ALU with operands: A, B, FUN.
  - 0xDD ALU without operands: FUN.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN, NOP_FUN, RD_WAIT, ALU_WAIT.
- IDLE + RX_D_VLD:
  - 0xAA → WR_ADDR; 0xBB → RD_ADDR; 0xCC → ALU_A; 0xDD → NOP_FUN.
  - Any other value → CMD_ERR=1 next cycle, stay IDLE.
- Write: WR_ADDR latches address → WR_DATA. WR_DATA byte valid at cycle N → RF_WR_EN=1, RF_ADDR and RF_WR_DATA valid at N+1 → IDLE.
- Read: RD_ADDR byte at N → RD_WAIT at N+1. RF_RD_EN=1 (with RF_ADDR) in the cycle after the first cycle k≥N+1 with TX_BUSY=0. Minimum latency is 2 cycles. Returns to IDLE with the strobe.
- ALU_A: byte at N → RF_WR_EN at N+1 with RF_ADDR=0, data=A → ALU_B.
- ALU_B: same with RF_ADDR=1 → ALU_FUN.
- ALU_FUN / NOP_FUN: latch ALU_FUN → ALU_WAIT. ALU_WAIT issues ALU_EN on the same TX_BUSY rule as RD_WAIT → IDLE.
- RF_ADDR, RF_WR_DATA and ALU_FUN hold their last value between strobes. Strobes are never asserted together.
- Timer:
  - Cleared on entry to any collection state (WR_ADDR…NOP_FUN) and on every accepted byte; increments otherwise.
  - Reaching TIMEOUT-1 in a collection state → CMD_ERR pulse, IDLE.
  - Inactive in IDLE and wait states.
- RX_ERR in a collection state → CMD_ERR pulse next cycle, IDLE. RX_ERR is ignored in IDLE and wait states.
- RX_ERR and RX_D_VLD in the same cycle: error wins, byte dropped.
- RX_D_VLD in RD_WAIT/ALU_WAIT: byte dropped, CMD_ERR pulse. The pending issue still completes.
- Upper P_DATA bits beyond ADDR_WIDTH are ignored for addresses; bits [7:4] are ignored for FUN.

Decomposition:
- Shared package uart_cmd_pkg: opcode constants (CMD_RF_WR=0xAA, CMD_RF_RD=0xBB, CMD_ALU_OP=0xCC, CMD_ALU_NOP=0xDD), state enumeration, operand addresses (OPA_ADDR=0, OPB_ADDR=1).
- One sub-module, uart_cmd_timer: inter-byte timeout counter with clear/enable inputs and an expire output, width $clog2(TIMEOUT).

Test Plan:
- Bytes AA,05,3C with TX_BUSY=0 → one RF_WR_EN pulse with RF_ADDR=5, RF_WR_DATA=0x3C, one cycle after the 3C valid; BUSY low afterwards.
- BB,07 with TX_BUSY held high 10 cycles after the address, then low → no RF_RD_EN while busy; single RF_RD_EN, RF_ADDR=7, exactly one cycle after TX_BUSY falls.
- CC,12,34,01 → RF writes (0,0x12) and (1,0x34), then ALU_EN with ALU_FUN=1. DD,0A → ALU_EN with ALU_FUN=0xA and no RF writes.
- Byte 0x55 in IDLE → CMD_ERR pulse, no strobes. Following AA,02,FF → write executes normally.
- With TIMEOUT=20: AA,03, then silence → CMD_ERR 20 cycles after the 03 valid, IDLE. AA,03 then RX_ERR with next byte → CMD_ERR, no RF_WR_EN.
- Assert RST while in ALU_B → all outputs 0 immediately. No strobe after release. The next frame AA,01,11 works.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_pkg
//  Description : Shared opcodes, operand addresses and sequencer state
//                encoding for the UART receive command controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

    // Frame opcodes (first byte of every command frame)
    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    // Register-file slots that hold the ALU operands
    localparam int OPA_ADDR = 0;
    localparam int OPB_ADDR = 1;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WR_ADDR  = 4'd1,
        ST_WR_DATA  = 4'd2,
        ST_RD_ADDR  = 4'd3,
        ST_ALU_A    = 4'd4,
        ST_ALU_B    = 4'd5,
        ST_ALU_FUN  = 4'd6,
        ST_NOP_FUN  = 4'd7,
        ST_RD_WAIT  = 4'd8,
        ST_ALU_WAIT = 4'd9
    } state_e;

    // Collection states are the ones still expecting frame bytes
    function automatic logic is_collect(input state_e s);
        return s inside {ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR, ST_ALU_A,
                         ST_ALU_B, ST_ALU_FUN, ST_NOP_FUN};
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cmd_timer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_timer
//  Description : Inter-byte timeout counter. Counts while enabled, clears on
//                request, and flags expiry on the cycle the count would step
//                onto TIMEOUT-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_timer #(
    parameter  int TIMEOUT = 50000,
    localparam int CNT_W   = $clog2(TIMEOUT)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    logic [CNT_W-1:0] r_count_q;
    logic [CNT_W-1:0] w_count_d;

    // Next count: clear wins over increment; hold when disabled
    always_comb begin
        w_count_d = r_count_q;
        if (i_clr) begin
            w_count_d = '0;
        end else if (i_en) begin
            w_count_d = r_count_q + CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    // Expire when this increment lands on TIMEOUT-1
    assign o_expire = i_en && !i_clr && (r_count_q == CNT_W'(TIMEOUT - 2));

endmodule
`default_nettype wire

// File: rtl/uart_rx_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_cmd_ctrl
//  Description : Parses command frames from the UART receiver and issues
//                single-cycle register-file write/read and ALU-start strobes.
//                Response-producing commands wait for the TX path to go idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 50000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic                  RX_ERR,
    input  logic                  TX_BUSY,
    output logic                  RF_WR_EN,
    output logic                  RF_RD_EN,
    output logic [ADDR_WIDTH-1:0] RF_ADDR,
    output logic [DATA_WIDTH-1:0] RF_WR_DATA,
    output logic                  ALU_EN,
    output logic [3:0]            ALU_FUN,
    output logic                  CMD_ERR,
    output logic                  BUSY
);

    state_e                r_state_q,      w_state_d;
    logic [ADDR_WIDTH-1:0] r_addr_q,       w_addr_d;       // latched frame address
    logic [3:0]            r_fun_q,        w_fun_d;        // latched ALU function
    logic                  r_wr_en_q,      w_wr_en_d;
    logic                  r_rd_en_q,      w_rd_en_d;
    logic                  r_alu_en_q,     w_alu_en_d;
    logic                  r_cmd_err_q,    w_cmd_err_d;
    logic                  r_busy_q,       w_busy_d;
    logic [ADDR_WIDTH-1:0] r_rf_addr_q,    w_rf_addr_d;
    logic [DATA_WIDTH-1:0] r_rf_wr_data_q, w_rf_wr_data_d;
    logic [3:0]            r_alu_fun_q,    w_alu_fun_d;

    logic w_in_collect;
    logic w_byte_ok;
    logic w_expire;

    assign w_in_collect = is_collect(r_state_q);
    // An error flag in the same cycle drops the byte
    assign w_byte_ok    = RX_D_VLD && !RX_ERR;

    // Timer restarts on every accepted byte and idles outside collection
    uart_cmd_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (CLK),
        .rst      (RST),
        .i_clr    (w_byte_ok || !w_in_collect),
        .i_en     (w_in_collect),
        .o_expire (w_expire)
    );

    // Next-state and registered-output computation
    always_comb begin
        w_state_d      = r_state_q;
        w_addr_d       = r_addr_q;
        w_fun_d        = r_fun_q;
        w_wr_en_d      = 1'b0;
        w_rd_en_d      = 1'b0;
        w_alu_en_d     = 1'b0;
        w_cmd_err_d    = 1'b0;
        w_rf_addr_d    = r_rf_addr_q;
        w_rf_wr_data_d = r_rf_wr_data_q;
        w_alu_fun_d    = r_alu_fun_q;

        if (w_in_collect && (RX_ERR || w_expire)) begin
            // Abort partial frame on receiver error or inter-byte timeout
            w_cmd_err_d = 1'b1;
            w_state_d   = ST_IDLE;
        end else begin
            case (r_state_q)
                ST_IDLE: begin
                    if (w_byte_ok) begin
                        if (RX_P_DATA == DATA_WIDTH'(CMD_RF_WR))        w_state_d = ST_WR_ADDR;
                        else if (RX_P_DATA == DATA_WIDTH'(CMD_RF_RD))   w_state_d = ST_RD_ADDR;
                        else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_OP))  w_state_d = ST_ALU_A;
                        else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_NOP)) w_state_d = ST_NOP_FUN;
                        else                                            w_cmd_err_d = 1'b1;
                    end
                end
                ST_WR_ADDR: begin
                    if (RX_D_VLD) begin
                        w_addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                        w_state_d = ST_WR_DATA;
                    end
                end
                ST_WR_DATA: begin
                    if (RX_D_VLD) begin
                        w_wr_en_d      = 1'b1;
                        w_rf_addr_d    = r_addr_q;
                        w_rf_wr_data_d = RX_P_DATA;
                        w_state_d      = ST_IDLE;
                    end
                end
                ST_RD_ADDR: begin
                    if (RX_D_VLD) begin
                        w_addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                        w_state_d = ST_RD_WAIT;
                    end
                end
                ST_ALU_A: begin
                    if (RX_D_VLD) begin
                        w_wr_en_d      = 1'b1;
                        w_rf_addr_d    = ADDR_WIDTH'(OPA_ADDR);
                        w_rf_wr_data_d = RX_P_DATA;
                        w_state_d      = ST_ALU_B;
                    end
                end
                ST_ALU_B: begin
                    if (RX_D_VLD) begin
                        w_wr_en_d      = 1'b1;
                        w_rf_addr_d    = ADDR_WIDTH'(OPB_ADDR);
                        w_rf_wr_data_d = RX_P_DATA;
                        w_state_d      = ST_ALU_FUN;
                    end
                end
                ST_ALU_FUN, ST_NOP_FUN: begin
                    if (RX_D_VLD) begin
                        w_fun_d   = RX_P_DATA[3:0];
                        w_state_d = ST_ALU_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    // Stray byte is rejected but the pending read still issues
                    w_cmd_err_d = RX_D_VLD;
                    if (!TX_BUSY) begin
                        w_rd_en_d   = 1'b1;
                        w_rf_addr_d = r_addr_q;
                        w_state_d   = ST_IDLE;
                    end
                end
                ST_ALU_WAIT: begin
                    w_cmd_err_d = RX_D_VLD;
                    if (!TX_BUSY) begin
                        w_alu_en_d  = 1'b1;
                        w_alu_fun_d = r_fun_q;
                        w_state_d   = ST_IDLE;
                    end
                end
                default: w_state_d = ST_IDLE;
            endcase
        end

        w_busy_d = (w_state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state_q      <= ST_IDLE;
            r_addr_q       <= '0;
            r_fun_q        <= '0;
            r_wr_en_q      <= 1'b0;
            r_rd_en_q      <= 1'b0;
            r_alu_en_q     <= 1'b0;
            r_cmd_err_q    <= 1'b0;
            r_busy_q       <= 1'b0;
            r_rf_addr_q    <= '0;
            r_rf_wr_data_q <= '0;
            r_alu_fun_q    <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_addr_q       <= w_addr_d;
            r_fun_q        <= w_fun_d;
            r_wr_en_q      <= w_wr_en_d;
            r_rd_en_q      <= w_rd_en_d;
            r_alu_en_q     <= w_alu_en_d;
            r_cmd_err_q    <= w_cmd_err_d;
            r_busy_q       <= w_busy_d;
            r_rf_addr_q    <= w_rf_addr_d;
            r_rf_wr_data_q <= w_rf_wr_data_d;
            r_alu_fun_q    <= w_alu_fun_d;
        end
    end

    assign RF_WR_EN   = r_wr_en_q;
    assign RF_RD_EN   = r_rd_en_q;
    assign ALU_EN     = r_alu_en_q;
    assign CMD_ERR    = r_cmd_err_q;
    assign BUSY       = r_busy_q;
    assign RF_ADDR    = r_rf_addr_q;
    assign RF_WR_DATA = r_rf_wr_data_q;
    assign ALU_FUN    = r_alu_fun_q;

endmodule
`default_nettype wire
